// File: rtl/color_event_filter_pkg.sv
// Shared color codes, event FSM encodings and helpers for the color sensor path.
// The sensor stage and the event filter both import this package.
package color_event_filter_pkg;

   typedef logic [2:0] color_t;

   localparam color_t COLOR_NONE  = 3'd0;
   localparam color_t COLOR_RED   = 3'd1;
   localparam color_t COLOR_GREEN = 3'd2;
   localparam color_t COLOR_BLUE  = 3'd3;

   localparam logic [0:0] EVT_EMPTY   = 1'b0;
   localparam logic [0:0] EVT_PENDING = 1'b1;

   typedef struct packed {
      logic [1:0] color;
      logic [3:0] seq;
   } evt_t;

   // Codes above BLUE are sensor glitches and read as "no color".
   function automatic color_t sanitize_color(input logic [2:0] raw);
      return (raw > COLOR_BLUE) ? COLOR_NONE : color_t'(raw);
   endfunction

endpackage

// File: rtl/color_event_filter_if.sv
// Valid/ready event channel from the color event filter to its consumer.
interface color_event_filter_if;
   logic       evt_valid;
   logic       evt_ready;
   logic [1:0] evt_color;
   logic [3:0] evt_seq;

   modport master (output evt_valid, output evt_color, output evt_seq, input  evt_ready);
   modport slave  (input  evt_valid, input  evt_color, input  evt_seq, output evt_ready);
endinterface

// File: rtl/color_event_filter_debounce.sv
// color_debounce: accepts a color once it has been seen unchanged for STABLE_CYCLES
// further samples; qualify_o is a combinational strobe valid on the accepting edge.
module color_debounce
   import color_event_filter_pkg::*;
#(
   parameter int STABLE_CYCLES = 2400
) (
   input  logic   clk,
   input  logic   rst,
   input  color_t color_i,
   output color_t stable_color_o,
   output color_t qual_color_o,
   output logic   qualify_o
);

   localparam logic [11:0] RUN_MAX = 12'(STABLE_CYCLES - 1);

   color_t      sample;
   color_t      cand_q, cand_d;
   color_t      stable_q, stable_d;
   logic [11:0] run_q, run_d;
   logic        qualify;

   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      sample   = sanitize_color(color_i);
      cand_d   = cand_q;
      run_d    = run_q;
      stable_d = stable_q;
      qualify  = 1'b0;
      if (sample != cand_q) begin
         cand_d = sample;
         run_d  = '0;
      end else if (run_q == RUN_MAX) begin
         qualify = (cand_q != stable_q);
      end else begin
         run_d = run_q + 12'd1;
      end
      if (qualify) stable_d = cand_q;
   end

   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous and active-low, so it lives inside the clocked branch.
      if (!rst) begin
         cand_q   <= COLOR_NONE;
         run_q    <= '0;
         stable_q <= COLOR_NONE;
      end else begin
         cand_q   <= cand_d;
         run_q    <= run_d;
         stable_q <= stable_d;
      end
   end

   assign stable_color_o = stable_q;
   assign qual_color_o   = cand_q;
   assign qualify_o      = qualify;

endmodule

// File: rtl/color_event_filter.sv
// Debounced color event source with a single-entry valid/ready event buffer.
// Define COLOR_EVT_COUNT_EN to add saturating per-color qualification counters.
module color_event_filter
   import color_event_filter_pkg::*;
#(
   parameter int STABLE_CYCLES = 2400
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [2:0]           color_in,
   color_event_filter_if.master evt,
   output logic [2:0]           stable_color,
   output logic                 overflow
`ifdef COLOR_EVT_COUNT_EN
   ,
   output logic [7:0]           cnt_red,
   output logic [7:0]           cnt_green,
   output logic [7:0]           cnt_blue
`endif
);

   color_t     qual_color;
   logic       qualify;
   logic       new_evt;
   logic       transfer;
   logic [0:0] state_q, state_d;
   evt_t       evt_q, evt_d;
   logic [3:0] seq_cnt_q, seq_cnt_d;
   logic       overflow_q, overflow_d;

   color_debounce #(.STABLE_CYCLES(STABLE_CYCLES)) u_debounce (
      .clk            (clk),
      .rst            (rst),
      .color_i        (color_in),
      .stable_color_o (stable_color),
      .qual_color_o   (qual_color),
      .qualify_o      (qualify)
   );

   assign new_evt  = qualify && (qual_color != COLOR_NONE);
   assign transfer = (state_q == EVT_PENDING) && evt.evt_ready;

   always_comb begin
      state_d    = state_q;
      evt_d      = evt_q;
      overflow_d = overflow_q;
      seq_cnt_d  = transfer ? seq_cnt_q + 4'd1 : seq_cnt_q;
      if (transfer) state_d = EVT_EMPTY;
      // A slot freed on this edge can take the new event with the advanced sequence.
      if (new_evt) begin
         if ((state_q == EVT_EMPTY) || transfer) begin
            state_d     = EVT_PENDING;
            evt_d.color = qual_color[1:0];
            evt_d.seq   = seq_cnt_d;
         end else begin
            overflow_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= EVT_EMPTY;
         evt_q      <= '0;
         seq_cnt_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         evt_q      <= evt_d;
         seq_cnt_q  <= seq_cnt_d;
         overflow_q <= overflow_d;
      end
   end

   assign evt.evt_valid = (state_q == EVT_PENDING);
   assign evt.evt_color = evt_q.color;
   assign evt.evt_seq   = evt_q.seq;
   assign overflow      = overflow_q;

`ifdef COLOR_EVT_COUNT_EN
   logic [7:0] cnt_red_q, cnt_green_q, cnt_blue_q;

   // Dropped events still count: these track qualifications, not deliveries.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_red_q   <= '0;
         cnt_green_q <= '0;
         cnt_blue_q  <= '0;
      end else if (new_evt) begin
         case (qual_color)
            COLOR_RED:   if (cnt_red_q   != 8'hFF) cnt_red_q   <= cnt_red_q   + 8'd1;
            COLOR_GREEN: if (cnt_green_q != 8'hFF) cnt_green_q <= cnt_green_q + 8'd1;
            COLOR_BLUE:  if (cnt_blue_q  != 8'hFF) cnt_blue_q  <= cnt_blue_q  + 8'd1;
            default: ;
         endcase
      end
   end

   assign cnt_red   = cnt_red_q;
   assign cnt_green = cnt_green_q;
   assign cnt_blue  = cnt_blue_q;
`endif

endmodule

// File: tb/tb_color_event_filter.sv
// Directed self-checking bench for color_event_filter with STABLE_CYCLES=4
// (a color must be held 5 edges to qualify).
module tb_color_event_filter;

   localparam int SC = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] color_in;
   logic [2:0] stable_color;
   logic       overflow;
`ifdef COLOR_EVT_COUNT_EN
   logic [7:0] cnt_red, cnt_green, cnt_blue;
`endif

   int n_chk = 0;
   int n_bad = 0;

   color_event_filter_if evt_if ();

   color_event_filter #(.STABLE_CYCLES(SC)) dut (
      .clk          (clk),
      .rst          (rst),
      .color_in     (color_in),
      .evt          (evt_if),
      .stable_color (stable_color),
      .overflow     (overflow)
`ifdef COLOR_EVT_COUNT_EN
      ,
      .cnt_red      (cnt_red),
      .cnt_green    (cnt_green),
      .cnt_blue     (cnt_blue)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance n rising edges; outputs are then read 1 time unit after the edge.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_evt(input string tag, input logic v, input logic [1:0] c, input logic [3:0] s);
      check({tag, ".valid"}, 32'(evt_if.evt_valid), 32'(v));
      check({tag, ".color"}, 32'(evt_if.evt_color), 32'(c));
      check({tag, ".seq"},   32'(evt_if.evt_seq),   32'(s));
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick(1);
      rst = 1'b1;
   endtask

   initial begin
      rst              = 1'b0;
      color_in         = 3'd0;
      evt_if.evt_ready = 1'b0;
      tick(2);
      check_evt("reset", 1'b0, 2'd0, 4'd0);
      check("reset.stable",   32'(stable_color), 32'd0);
      check("reset.overflow", 32'(overflow),     32'd0);
      rst = 1'b1;

      // Red held: qualifies on the 5th edge, then transfers; holding red adds nothing.
      evt_if.evt_ready = 1'b1;
      color_in         = 3'd1;
      tick(4);
      check("red.edge4.valid", 32'(evt_if.evt_valid), 32'd0);
      tick(1);
      check_evt("red.edge5", 1'b1, 2'd1, 4'd0);
      check("red.stable", 32'(stable_color), 32'd1);
      tick(1);
      check("red.xfer.valid", 32'(evt_if.evt_valid), 32'd0);
      tick(6);
      check("red.hold.noevt", 32'(evt_if.evt_valid), 32'd0);

      // 2,2,3,2,2,2,2,2: only the final 2 qualifies; code 7 reads as none elsewhere.
      evt_if.evt_ready = 1'b0;
      begin
         logic [2:0] seq_in [8] = '{3'd2, 3'd2, 3'd3, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2};
         for (int i = 0; i < 7; i++) begin
            color_in = seq_in[i];
            tick(1);
            check($sformatf("glitch.e%0d.valid", i), 32'(evt_if.evt_valid), 32'd0);
         end
         color_in = seq_in[7];
         tick(1);
      end
      check_evt("green", 1'b1, 2'd2, 4'd1);
      check("green.stable", 32'(stable_color), 32'd2);
      evt_if.evt_ready = 1'b1;
      tick(1);
      check("green.xfer.valid", 32'(evt_if.evt_valid), 32'd0);
      color_in = 3'd7;
      tick(5);
      check("code7.stable", 32'(stable_color), 32'd0);
      check("code7.valid",  32'(evt_if.evt_valid), 32'd0);

      // Overflow: red pending, none qualifies silently, blue is dropped.
      do_reset();
      evt_if.evt_ready = 1'b0;
      color_in = 3'd1;
      tick(5);
      check_evt("ovf.red", 1'b1, 2'd1, 4'd0);
      color_in = 3'd0;
      tick(5);
      check("ovf.none.stable", 32'(stable_color), 32'd0);
      check("ovf.none.ovf",    32'(overflow),     32'd0);
      color_in = 3'd3;
      tick(5);
      check_evt("ovf.blue", 1'b1, 2'd1, 4'd0);
      check("ovf.blue.stable", 32'(stable_color), 32'd3);
      check("ovf.blue.ovf",    32'(overflow),     32'd1);
`ifdef COLOR_EVT_COUNT_EN
      check("ovf.cnt_red",  32'(cnt_red),  32'd1);
      check("ovf.cnt_blue", 32'(cnt_blue), 32'd1);
`endif
      evt_if.evt_ready = 1'b1;
      tick(1);
      check("ovf.xfer.valid", 32'(evt_if.evt_valid), 32'd0);
      check("ovf.sticky",     32'(overflow),         32'd1);

      // Transfer and new event on the same edge.
      do_reset();
      evt_if.evt_ready = 1'b0;
      color_in = 3'd1;
      tick(5);
      check_evt("same.first", 1'b1, 2'd1, 4'd0);
      color_in = 3'd2;
      tick(4);
      evt_if.evt_ready = 1'b1;
      tick(1);
      check_evt("same.second", 1'b1, 2'd2, 4'd1);
      check("same.ovf", 32'(overflow), 32'd0);
      tick(1);
      check("same.drain.valid", 32'(evt_if.evt_valid), 32'd0);
      tick(3);
      check("empty.ready.ignored", 32'(evt_if.evt_valid), 32'd0);

      // Reset mid-PENDING, with overflow set and ready high on the same edge.
      evt_if.evt_ready = 1'b0;
      color_in = 3'd3;
      tick(5);
      check_evt("rstp.pend", 1'b1, 2'd3, 4'd2);
      color_in = 3'd1;
      tick(5);
      check("rstp.ovf", 32'(overflow), 32'd1);
      evt_if.evt_ready = 1'b1;
      do_reset();
      check_evt("rstp.after", 1'b0, 2'd0, 4'd0);
      check("rstp.stable", 32'(stable_color), 32'd0);
      check("rstp.ovf0",   32'(overflow),     32'd0);
`ifdef COLOR_EVT_COUNT_EN
      check("rstp.cnt_red",  32'(cnt_red),  32'd0);
      check("rstp.cnt_blue", 32'(cnt_blue), 32'd0);
`endif

      // Sequence wrap: 17 red events delivered, the 17th carries seq 0.
      color_in = 3'd0;
      tick(1);
      for (int k = 0; k < 17; k++) begin
         color_in = 3'd1;
         tick(5);
         check_evt($sformatf("wrap.k%0d", k), 1'b1, 2'd1, 4'(k % 16));
         color_in = 3'd0;
         tick(5);
      end
      check("wrap.ovf", 32'(overflow), 32'd0);
`ifdef COLOR_EVT_COUNT_EN
      check("cnt.red17", 32'(cnt_red), 32'd17);
      for (int k = 17; k < 300; k++) begin
         color_in = 3'd1;
         tick(5);
         color_in = 3'd0;
         tick(5);
      end
      check("cnt.red.sat", 32'(cnt_red),   32'd255);
      check("cnt.green",   32'(cnt_green), 32'd0);
      check("cnt.blue",    32'(cnt_blue),  32'd0);
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/color_event_filter.md
COLOR_EVENT_FILTER -- requirements
Module: color_event_filter

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 2400 (0.3 s at 8 kHz clk), meaning consecutive identical samples required to accept a color; legal range 2..4095.
REQ-002 The block SHALL have port clk  input  1  base clock, same 8 kHz domain as the color sensor stage.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port color_in  input  3  raw color code from the sensor stage: 0 none, 1 red, 2 green, 3 blue.
REQ-005 The block SHALL have port evt_valid  output  1  event available.
REQ-006 The block SHALL have port evt_ready  input  1  downstream accepts event.
REQ-007 The block SHALL have port evt_color  output  2  color of pending event, 1..3.
REQ-008 The block SHALL have port evt_seq  output  4  sequence number of pending event.
REQ-009 The block SHALL have port stable_color  output  3  last debounced color, 0..3.
REQ-010 The block SHALL have port overflow  output  1  sticky, event dropped.
REQ-011 The block SHALL have ports cnt_red, cnt_green, cnt_blue  output  8 each  per-color qualification counts, present only per REQ-026.

Function
REQ-012 The block SHALL treat color_in values 4..7 as 0.
REQ-013 The block SHALL hold a candidate register and a 12-bit run counter: color_in != candidate -> candidate <= color_in, run <= 0; else run increments, saturating at STABLE_CYCLES-1.
REQ-014 The block SHALL qualify on the edge where run == STABLE_CYCLES-1 and candidate != stable_color: stable_color <= candidate on that edge; color_in constant for STABLE_CYCLES+1 edges (one to load candidate plus STABLE_CYCLES runs) therefore yields stable_color update.
REQ-015 A qualification to 0 SHALL update stable_color only; no event; re-presenting the previous color afterwards SHALL qualify again.
REQ-016 A qualification to 1..3 SHALL generate an event; repeated identical color with no intermediate qualification SHALL NOT.
REQ-017 Event FSM states EMPTY, PENDING: EMPTY + event -> PENDING, evt_valid=1 on the qualifying edge, evt_color/evt_seq loaded.
REQ-018 In PENDING evt_color and evt_seq SHALL stay constant until evt_valid && evt_ready on an edge; then -> EMPTY, evt_valid=0, internal seq counter +1 (4-bit wrap 15->0).
REQ-019 Transfer and new event on the same edge SHALL load the new event with the incremented seq and remain PENDING; no overflow.
REQ-020 New event in PENDING without transfer SHALL be dropped, pending event kept, overflow <= 1 until reset; seq not incremented.
REQ-021 evt_ready while EMPTY SHALL be ignored.

Reset
REQ-022 rst==0 at an edge SHALL set candidate=0, run=0, stable_color=0, evt_valid=0, evt_color=0, evt_seq=0, seq counter=0, overflow=0, counters=0, FSM=EMPTY.
REQ-023 Reset mid-PENDING SHALL discard the event without a transfer.
REQ-024 Reset SHALL dominate all other same-edge events.

Configuration
REQ-025 Macro COLOR_EVT_COUNT_EN SHALL control per-color counters.
REQ-026 With COLOR_EVT_COUNT_EN defined: cnt_red/green/blue exist, increment on every 1..3 qualification including dropped ones, saturate at 255. Without: ports and logic absent, all other behaviour identical.

Structure
REQ-027 A shared package SHALL hold color code constants (NONE=0, RED=1, GREEN=2, BLUE=3), the 3-bit color type and event FSM state encodings; the sensor stage SHALL use the same constants.
REQ-028 Candidate/run logic SHALL be sub-module color_debounce (outputs stable_color and a one-cycle qualify strobe); event FSM and counters stay in the top.

Verification (bench STABLE_CYCLES=4)
REQ-029 Reset, color_in=1 held 5 edges, evt_ready=1 -> evt_valid 1 on the 5th edge, evt_color=1, evt_seq=0; stable_color=1.
REQ-030 color_in 2,2,3,2,2,2,2,2 -> single event color 2 after the last 2 in sequence; no event for 3.
REQ-031 evt_ready=0, qualify 1 then 0 then 3 -> evt_color stays 1, overflow=1, evt_seq=0; ready=1 -> transfer, EMPTY.
REQ-032 Ready asserted on the exact qualifying edge of a second event -> evt_valid stays 1, evt_seq=1, overflow=0.
REQ-033 17 alternating red/none cycles with ready=1 -> evt_seq wraps 15->0; with COLOR_EVT_COUNT_EN, 300 red qualifications -> cnt_red=255.
REQ-034 rst=0 while PENDING -> next edge evt_valid=0, all outputs zero.
